// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
// Shares the single 100-cell Othello board RAM between the board initializer,
// the game logic (move check / flip engine) and the display scanner. One
// access is granted per cycle; reads are tracked through the RAM latency and
// their data is returned to the requester that issued them.
//
// Handshake (all three requesters): a requester raises req with addr/wdata/
// wren and holds them stable until it sees its gnt high in the same cycle.
// The access is performed in that gnt cycle. gnt is never high without req.
// Read data comes back RD_LATENCY cycles after the gnt cycle as a one-cycle
// rvalid pulse; rdata keeps its last returned value between pulses.
module board_mem_arbiter #(
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 8,
   parameter int BOARD_CELLS  = 100
) (
   input  logic       clock,
   input  logic       reset,

   input  logic       init_req,
   input  logic [6:0] init_addr,
   input  logic [1:0] init_wdata,
   input  logic       init_wren,
   output logic       init_gnt,

   input  logic       logic_req,
   input  logic       logic_lock,
   input  logic [6:0] logic_addr,
   input  logic [1:0] logic_wdata,
   input  logic       logic_wren,
   output logic       logic_gnt,
   output logic [1:0] logic_rdata,
   output logic       logic_rvalid,

   input  logic       disp_req,
   input  logic [6:0] disp_addr,
   output logic       disp_gnt,
   output logic [1:0] disp_rdata,
   output logic       disp_rvalid,

   output logic [6:0] mem_addr,
   output logic [1:0] mem_wdata,
   output logic       mem_wren,
   input  logic [1:0] mem_rdata,

   output logic [1:0] owner
);

   // Owner encoding doubles as the grant state visible on the owner port.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'b00,
      OWN_INIT  = 2'b01,
      OWN_LOGIC = 2'b10,
      OWN_DISP  = 2'b11
   } owner_e;

   // One entry per read in flight; only logic/display reads are marked valid.
   typedef struct packed {
      logic   vld;
      owner_e own;
      logic   oor;
   } rd_tag_t;

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [1:0] BORDER_CELL = 2'b11;

   owner_e           gnt_own;
   logic [6:0]       sel_addr;
   logic [1:0]       sel_wdata;
   logic             sel_wren;
   logic             sel_oor;

   logic             lock_q, lock_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [6:0]       addr_q;

   rd_tag_t          tag_in;
   rd_tag_t          tag_q [RD_LATENCY];
   rd_tag_t          tag_out;
   logic [1:0]       ret_data;
   logic [1:0]       logic_rdata_q;
   logic [1:0]       disp_rdata_q;

   // Fixed-priority grant: init, locked logic, starved display, logic, display.
   // Nothing is granted while reset is asserted.
   always_comb begin
      gnt_own = OWN_NONE;
      if (reset) begin
         if (init_req)
            gnt_own = OWN_INIT;
         else if (lock_q && logic_req)
            gnt_own = OWN_LOGIC;
         else if ((starve_q == STARVE_MAX) && disp_req)
            gnt_own = OWN_DISP;
         else if (logic_req)
            gnt_own = OWN_LOGIC;
         else if (disp_req)
            gnt_own = OWN_DISP;
      end
   end

   // Select the granted requester's address/data; display never writes.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wren  = 1'b0;
      case (gnt_own)
         OWN_INIT: begin
            sel_addr  = init_addr;
            sel_wdata = init_wdata;
            sel_wren  = init_wren;
         end
         OWN_LOGIC: begin
            sel_addr  = logic_addr;
            sel_wdata = logic_wdata;
            sel_wren  = logic_wren;
         end
         OWN_DISP: begin
            sel_addr  = disp_addr;
         end
         default: ;
      endcase
   end

   assign sel_oor = (gnt_own != OWN_NONE) &&
                    ({25'd0, sel_addr} >= 32'(BOARD_CELLS));

   // Drive the RAM port; out-of-range accesses are parked at cell 0 with
   // writes suppressed, and the address holds its last value when idle.
   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = '0;
      mem_wren  = 1'b0;
      if (gnt_own != OWN_NONE) begin
         mem_addr  = sel_oor ? 7'd0 : sel_addr;
         mem_wdata = sel_wdata;
         mem_wren  = sel_wren && !sel_oor;
      end
   end

   assign init_gnt  = (gnt_own == OWN_INIT);
   assign logic_gnt = (gnt_own == OWN_LOGIC);
   assign disp_gnt  = (gnt_own == OWN_DISP);
   assign owner     = gnt_own;

   // Next lock flag and starvation count from this cycle's requests/grants.
   always_comb begin
      lock_d   = lock_q;
      starve_d = starve_q;

      if (gnt_own == OWN_INIT)
         lock_d = 1'b0;
      else if (gnt_own == OWN_LOGIC)
         lock_d = logic_lock;
      else if (!logic_req)
         lock_d = 1'b0;

      if (disp_gnt || !disp_req)
         starve_d = '0;
      else if (init_req)
         starve_d = starve_q;
      else if (starve_q != STARVE_MAX)
         starve_d = starve_q + CNT_W'(1);
   end

   // Tag for a read issued this cycle; init reads are not returned.
   always_comb begin
      tag_in     = '0;
      tag_in.vld = ((gnt_own == OWN_LOGIC) || (gnt_own == OWN_DISP)) && !sel_wren;
      tag_in.own = gnt_own;
      tag_in.oor = sel_oor;
   end

   // Arbitration state and the idle-hold copy of the RAM address.
   always_ff @(posedge clock) begin
      if (!reset) begin
         lock_q   <= 1'b0;
         starve_q <= '0;
         addr_q   <= '0;
      end else begin
         lock_q   <= lock_d;
         starve_q <= starve_d;
         addr_q   <= mem_addr;
      end
   end

   // Read-tag shift pipeline matching the RAM read latency; reset drops
   // anything in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < RD_LATENCY; i++)
            tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < RD_LATENCY; i++)
            tag_q[i] <= tag_q[i-1];
      end
   end

   assign tag_out  = tag_q[RD_LATENCY-1];
   assign ret_data = tag_out.oor ? BORDER_CELL : mem_rdata;

   assign logic_rvalid = reset && tag_out.vld && (tag_out.own == OWN_LOGIC);
   assign disp_rvalid  = reset && tag_out.vld && (tag_out.own == OWN_DISP);

   // Returned data is live on the pulse, then held from the capture register.
   assign logic_rdata = logic_rvalid ? ret_data : logic_rdata_q;
   assign disp_rdata  = disp_rvalid  ? ret_data : disp_rdata_q;

   // Capture returned data so rdata holds between pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         logic_rdata_q <= '0;
         disp_rdata_q  <= '0;
      end else begin
         if (logic_rvalid)
            logic_rdata_q <= ret_data;
         if (disp_rvalid)
            disp_rdata_q <= ret_data;
      end
   end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: one instance at RD_LATENCY=1 and a
// second at RD_LATENCY=2 share all requester inputs, each with its own
// read-latency model of the board RAM.
module tb_board_mem_arbiter;

   logic       clock;
   logic       reset;

   logic       init_req;
   logic [6:0] init_addr;
   logic [1:0] init_wdata;
   logic       init_wren;
   logic       logic_req;
   logic       logic_lock;
   logic [6:0] logic_addr;
   logic [1:0] logic_wdata;
   logic       logic_wren;
   logic       disp_req;
   logic [6:0] disp_addr;

   // latency-1 instance
   logic       init_gnt, logic_gnt, disp_gnt;
   logic [1:0] logic_rdata, disp_rdata;
   logic       logic_rvalid, disp_rvalid;
   logic [6:0] mem_addr;
   logic [1:0] mem_wdata;
   logic       mem_wren;
   logic [1:0] mem_rdata;
   logic [1:0] owner;

   // latency-2 instance
   logic       init_gnt_b, logic_gnt_b, disp_gnt_b;
   logic [1:0] logic_rdata_b, disp_rdata_b;
   logic       logic_rvalid_b, disp_rvalid_b;
   logic [6:0] mem_addr_b;
   logic [1:0] mem_wdata_b;
   logic       mem_wren_b;
   logic [1:0] mem_rdata_b;
   logic [1:0] owner_b;

   logic [1:0] ram [128];
   logic [1:0] rd2_stage;

   int vectors;
   int miscompares;

   board_mem_arbiter #(.RD_LATENCY(1), .STARVE_LIMIT(8), .BOARD_CELLS(100)) dut (
      .clock(clock), .reset(reset),
      .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata),
      .init_wren(init_wren), .init_gnt(init_gnt),
      .logic_req(logic_req), .logic_lock(logic_lock), .logic_addr(logic_addr),
      .logic_wdata(logic_wdata), .logic_wren(logic_wren), .logic_gnt(logic_gnt),
      .logic_rdata(logic_rdata), .logic_rvalid(logic_rvalid),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   board_mem_arbiter #(.RD_LATENCY(2), .STARVE_LIMIT(8), .BOARD_CELLS(100)) dut_b (
      .clock(clock), .reset(reset),
      .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata),
      .init_wren(init_wren), .init_gnt(init_gnt_b),
      .logic_req(logic_req), .logic_lock(logic_lock), .logic_addr(logic_addr),
      .logic_wdata(logic_wdata), .logic_wren(logic_wren), .logic_gnt(logic_gnt_b),
      .logic_rdata(logic_rdata_b), .logic_rvalid(logic_rvalid_b),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt_b),
      .disp_rdata(disp_rdata_b), .disp_rvalid(disp_rvalid_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wren(mem_wren_b),
      .mem_rdata(mem_rdata_b), .owner(owner_b)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [1:0] ram_init(input int a);
      case (a)
         33:      return 2'b10;
         44:      return 2'b10;
         55:      return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Board RAM model: preloaded during reset, written by the latency-1
   // instance, read with 1- and 2-cycle latency for the two instances.
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 128; i++)
            ram[i] <= ram_init(i);
      end else if (mem_wren) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata   <= ram[mem_addr];
      rd2_stage   <= ram[mem_addr_b];
      mem_rdata_b <= rd2_stage;
   end

   // driver tasks
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      init_req    = 1'b0;
      init_addr   = '0;
      init_wdata  = '0;
      init_wren   = 1'b0;
      logic_req   = 1'b0;
      logic_lock  = 1'b0;
      logic_addr  = '0;
      logic_wdata = '0;
      logic_wren  = 1'b0;
      disp_req    = 1'b0;
      disp_addr   = '0;
   endtask

   // scoreboard comparison
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_init_gnt"},  8'(init_gnt),     8'd0);
      chk({tag, "_logic_gnt"}, 8'(logic_gnt),    8'd0);
      chk({tag, "_disp_gnt"},  8'(disp_gnt),     8'd0);
      chk({tag, "_owner"},     8'(owner),        8'd0);
      chk({tag, "_mem_wren"},  8'(mem_wren),     8'd0);
      chk({tag, "_mem_addr"},  8'(mem_addr),     8'd0);
      chk({tag, "_mem_wdata"}, 8'(mem_wdata),    8'd0);
      chk({tag, "_lrvalid"},   8'(logic_rvalid), 8'd0);
      chk({tag, "_drvalid"},   8'(disp_rvalid),  8'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      clear_inputs();

      // reset values
      repeat (3) cyc();
      #2;
      chk_reset_outputs("rst");
      cyc();
      reset = 1'b1;

      // priority: all three request, init writes cell 45 with white
      init_req = 1'b1; init_addr = 7'd45; init_wdata = 2'b10; init_wren = 1'b1;
      logic_req = 1'b1; logic_addr = 7'd10;
      disp_req = 1'b1; disp_addr = 7'd20;
      #2;
      chk("prio_init_gnt",  8'(init_gnt),  8'd1);
      chk("prio_logic_gnt", 8'(logic_gnt), 8'd0);
      chk("prio_disp_gnt",  8'(disp_gnt),  8'd0);
      chk("prio_owner",     8'(owner),     8'd1);
      chk("prio_wren",      8'(mem_wren),  8'd1);
      chk("prio_addr",      8'(mem_addr),  8'd45);
      chk("prio_wdata",     8'(mem_wdata), 8'd2);
      cyc();
      clear_inputs();
      #2;
      chk("prio_ram45",     8'(ram[45]),   8'd2);
      chk("idle_hold_addr", 8'(mem_addr),  8'd45);
      chk("idle_wren",      8'(mem_wren),  8'd0);
      chk("idle_owner",     8'(owner),     8'd0);

      // init read returns nothing
      cyc();
      init_req = 1'b1; init_addr = 7'd55;
      #2;
      chk("iread_gnt", 8'(init_gnt), 8'd1);
      cyc();
      clear_inputs();
      #2;
      chk("iread_lrv",  8'(logic_rvalid), 8'd0);
      chk("iread_drv",  8'(disp_rvalid),  8'd0);
      cyc();
      #2;
      chk("iread_lrv_b", 8'(logic_rvalid_b), 8'd0);
      chk("iread_drv_b", 8'(disp_rvalid_b),  8'd0);

      // read latency: logic reads cell 55 (black)
      cyc();
      logic_req = 1'b1; logic_addr = 7'd55;
      #2;
      chk("lat_gnt",   8'(logic_gnt),    8'd1);
      chk("lat_owner", 8'(owner),        8'd2);
      chk("lat_addr",  8'(mem_addr),     8'd55);
      chk("lat_wren",  8'(mem_wren),     8'd0);
      chk("lat_rv0",   8'(logic_rvalid), 8'd0);
      cyc();
      clear_inputs();
      #2;
      chk("lat1_rv",    8'(logic_rvalid),   8'd1);
      chk("lat1_rdata", 8'(logic_rdata),    8'd1);
      chk("lat2_rv_e",  8'(logic_rvalid_b), 8'd0);
      cyc();
      #2;
      chk("lat1_rv_off", 8'(logic_rvalid),   8'd0);
      chk("lat1_hold",   8'(logic_rdata),    8'd1);
      chk("lat2_rv",     8'(logic_rvalid_b), 8'd1);
      chk("lat2_rdata",  8'(logic_rdata_b),  8'd1);
      cyc();
      #2;
      chk("lat2_rv_off", 8'(logic_rvalid_b), 8'd0);

      // back-to-back reads: 55 (black) then 44 (white)
      cyc();
      logic_req = 1'b1; logic_addr = 7'd55;
      cyc();
      logic_addr = 7'd44;
      #2;
      chk("b2b_rv1",    8'(logic_rvalid), 8'd1);
      chk("b2b_data1",  8'(logic_rdata),  8'd1);
      cyc();
      clear_inputs();
      #2;
      chk("b2b_rv2",    8'(logic_rvalid),   8'd1);
      chk("b2b_data2",  8'(logic_rdata),    8'd2);
      chk("b2b_rv1_b",  8'(logic_rvalid_b), 8'd1);
      chk("b2b_data1_b",8'(logic_rdata_b),  8'd1);
      cyc();
      #2;
      chk("b2b_rv_off", 8'(logic_rvalid),   8'd0);
      chk("b2b_rv2_b",  8'(logic_rvalid_b), 8'd1);
      chk("b2b_data2_b",8'(logic_rdata_b),  8'd2);
      chk("b2b_hold_addr", 8'(mem_addr),    8'd44);

      // lock burst: five locked writes hold off a waiting display
      cyc();
      disp_req = 1'b1; disp_addr = 7'd33;
      logic_req = 1'b1; logic_lock = 1'b1; logic_wren = 1'b1; logic_wdata = 2'b01;
      for (int i = 0; i < 5; i++) begin
         logic_addr = 7'(60 + i);
         #2;
         chk("lock_logic_gnt", 8'(logic_gnt), 8'd1);
         chk("lock_disp_gnt",  8'(disp_gnt),  8'd0);
         cyc();
      end
      logic_lock = 1'b0; logic_addr = 7'd65;
      #2;
      chk("unlock_logic_gnt", 8'(logic_gnt), 8'd1);
      chk("unlock_disp_gnt",  8'(disp_gnt),  8'd0);
      cyc();
      logic_req = 1'b0; logic_wren = 1'b0;
      #2;
      chk("after_lock_disp_gnt", 8'(disp_gnt), 8'd1);
      chk("after_lock_owner",    8'(owner),    8'd3);
      chk("after_lock_addr",     8'(mem_addr), 8'd33);
      chk("after_lock_wren",     8'(mem_wren), 8'd0);
      cyc();
      disp_req = 1'b0;
      #2;
      chk("disp_rv",    8'(disp_rvalid), 8'd1);
      chk("disp_rdata", 8'(disp_rdata),  8'd2);
      chk("lock_ram62", 8'(ram[62]),     8'd1);

      // starvation: display wins on the ninth contended cycle
      cyc();
      logic_req = 1'b1; logic_wren = 1'b1; logic_addr = 7'd70; logic_wdata = 2'b11;
      disp_req = 1'b1; disp_addr = 7'd55;
      for (int i = 0; i < 8; i++) begin
         #2;
         chk("starve_logic_gnt", 8'(logic_gnt), 8'd1);
         chk("starve_disp_gnt",  8'(disp_gnt),  8'd0);
         cyc();
      end
      #2;
      chk("starve9_disp_gnt",  8'(disp_gnt),  8'd1);
      chk("starve9_logic_gnt", 8'(logic_gnt), 8'd0);
      chk("starve9_owner",     8'(owner),     8'd3);
      cyc();
      #2;
      chk("resume_logic_gnt", 8'(logic_gnt),   8'd1);
      chk("resume_disp_gnt",  8'(disp_gnt),    8'd0);
      chk("starve_disp_rv",   8'(disp_rvalid), 8'd1);
      chk("starve_disp_data", 8'(disp_rdata),  8'd1);
      cyc();
      clear_inputs();

      // out of range: logic writes 127, display reads 100
      cyc();
      logic_req = 1'b1; logic_wren = 1'b1; logic_addr = 7'd127; logic_wdata = 2'b10;
      disp_req = 1'b1; disp_addr = 7'd100;
      #2;
      chk("oor_w_gnt",  8'(logic_gnt), 8'd1);
      chk("oor_w_wren", 8'(mem_wren),  8'd0);
      chk("oor_w_addr", 8'(mem_addr),  8'd0);
      cyc();
      logic_req = 1'b0; logic_wren = 1'b0;
      #2;
      chk("oor_r_gnt",  8'(disp_gnt),     8'd1);
      chk("oor_r_addr", 8'(mem_addr),     8'd0);
      chk("oor_r_wren", 8'(mem_wren),     8'd0);
      chk("oor_w_norv", 8'(logic_rvalid), 8'd0);
      cyc();
      disp_req = 1'b0;
      #2;
      chk("oor_rv",     8'(disp_rvalid),  8'd1);
      chk("oor_rdata",  8'(disp_rdata),   8'd3);
      chk("oor_lrv",    8'(logic_rvalid), 8'd0);
      chk("oor_ram0",   8'(ram[0]),       8'd0);
      chk("oor_ram127", 8'(ram[127]),     8'd0);
      cyc();
      #2;
      chk("oor_rv_b",    8'(disp_rvalid_b), 8'd1);
      chk("oor_rdata_b", 8'(disp_rdata_b),  8'd3);

      // reset while a logic read of cell 44 is in flight
      cyc();
      logic_req = 1'b1; logic_addr = 7'd44;
      #2;
      chk("rmid_gnt", 8'(logic_gnt), 8'd1);
      cyc();
      clear_inputs();
      reset = 1'b0;
      #2;
      chk("rmid_lrv",   8'(logic_rvalid), 8'd0);
      chk("rmid_owner", 8'(owner),        8'd0);
      cyc();
      #2;
      chk_reset_outputs("rmid");
      chk("rmid_lrv_b", 8'(logic_rvalid_b), 8'd0);
      reset = 1'b1;
      cyc();
      #2;
      chk("rmid_post_lrv",   8'(logic_rvalid),   8'd0);
      chk("rmid_post_lrv_b", 8'(logic_rvalid_b), 8'd0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
